// File: rtl/p405s_srm_pkg.sv
// Shared SRM definitions: field widths, CR0 bit positions, reference mask function.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package p405s_srm_pkg;

    localparam int DW  = 32;
    localparam int SHW = 5;

    // CR0 bit positions, big-endian numbering (0 = MSB of the 4-bit field)
    localparam int CR0_LT = 0;
    localparam int CR0_GT = 1;
    localparam int CR0_EQ = 2;
    localparam int CR0_SO = 3;

    // Reference mask, bit-by-bit in big-endian order. Intended for scoreboards only.
    function automatic logic [DW-1:0] ref_mask(input logic [SHW-1:0] mb,
                                               input logic [SHW-1:0] me,
                                               input logic           force_zero);
        logic [DW-1:0] m;
        int            b;
        int            e;
        m = '0;
        b = int'(mb);
        e = int'(me);
        for (int p = 0; p < DW; p++) begin
            if (b <= e)
                m[DW-1-p] = (p >= b) && (p <= e);
            else
                m[DW-1-p] = (p >= b) || (p <= e);
        end
        if (force_zero)
            m = '0;
        return m;
    endfunction

endpackage

// File: rtl/p405s_srmMskLkAhd.sv
// SRM mask look-ahead: classifies mb/me ahead of the mask build (wrap / full range).
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module p405s_srmMskLkAhd
    import p405s_srm_pkg::*;
#(
    parameter int LSHW = SHW
) (
    input  logic [LSHW-1:0] mbField,
    input  logic [LSHW-1:0] meField,
    output logic [1:0]      propLookAhd
);

    // [1] = wrap-around mask (me < mb), [0] = full-range mask (mb=0, me=max)
    always_comb begin
        propLookAhd    = 2'b00;
        propLookAhd[1] = (meField < mbField);
        propLookAhd[0] = (mbField == '0) && (meField == '1);
    end

endmodule

// File: rtl/p405s_srm_exec_pipe.sv
// Two-stage rotate/mask/merge execute pipe for rlwinm, rlwnm, rlwimi, slw, srw with CR0 generation.
// Latency: 2 cycles accept-to-outVld, 1 op/cycle throughput.
// Backpressure: valid/ready; stalled stages hold, inRdy = ~s1Vld | s2Load (never depends on inVld).
module p405s_srm_exec_pipe
    import p405s_srm_pkg::*;
#(
    parameter int PDW  = DW,
    parameter int PSHW = SHW
) (
    input  logic            CB,
    input  logic            syncReset,
    input  logic            flush,
    input  logic            inVld,
    output logic            inRdy,
    input  logic [PDW-1:0]  rsData,
    input  logic [PDW-1:0]  raData,
    input  logic [PSHW-1:0] shAmt,
    input  logic [PSHW-1:0] mbField,
    input  logic [PSHW-1:0] meField,
    input  logic            forceZeroDcd,
    input  logic            insertOp,
    input  logic            recordOp,
    input  logic            soIn,
    output logic            outVld,
    input  logic            outRdy,
    output logic [PDW-1:0]  result,
    output logic [3:0]      cr0,
    output logic            cr0Vld
);

    // Valid bits and output registers
    logic            s1Vld_q;
    logic            s2Vld_q;
    logic            cr0Vld_q;
    logic [PDW-1:0]  result_q;
    logic [3:0]      cr0_q;

    // Stage-1 datapath registers (no reset needed)
    logic [PDW-1:0]  rot_q;
    logic [PDW-1:0]  ra_q;
    logic [PSHW-1:0] mb_q;
    logic [PSHW-1:0] me_q;
    logic            fz_q;
    logic            ins_q;
    logic            rec_q;
    logic            so_q;
    logic [1:0]      lkAhd_q;

    // Combinational
    logic            s2Load;
    logic            accept;
    logic [2*PDW-1:0] rotWide;
    logic [PDW-1:0]  rot_d;
    logic [1:0]      lkAhd_d;
    logic [PDW-1:0]  mskBegin;
    logic [PDW-1:0]  mskEnd;
    logic [PDW-1:0]  mask_d;
    logic [PDW-1:0]  result_d;
    logic [3:0]      cr0_d;

    // Handshake: flush blocks both the output advance and new accepts in its cycle
    always_comb begin
        s2Load = ~flush & (~s2Vld_q | outRdy);
        inRdy  = ~syncReset & ~flush & (~s1Vld_q | s2Load);
        accept = inVld & inRdy;
    end

    // Stage 1 rotator: left-rotate by shAmt via a doubled-word shift
    always_comb begin
        rotWide = {rsData, rsData} << shAmt;
        rot_d   = rotWide[2*PDW-1:PDW];
    end

    p405s_srmMskLkAhd #(
        .LSHW        (PSHW)
    ) u_lkahd (
        .mbField     (mbField),
        .meField     (meField),
        .propLookAhd (lkAhd_d)
    );

    // Stage 1 operand capture on accept
    always_ff @(posedge CB) begin
        if (accept) begin
            rot_q   <= rot_d;
            ra_q    <= raData;
            mb_q    <= mbField;
            me_q    <= meField;
            fz_q    <= forceZeroDcd;
            ins_q   <= insertOp;
            rec_q   <= recordOp;
            so_q    <= soIn;
            lkAhd_q <= lkAhd_d;
        end
    end

    // Stage 2 mask build and merge; wrap/full choice comes from the registered look-ahead
    always_comb begin
        mskBegin = {PDW{1'b1}} >> mb_q;                         // ones in bits mb..31
        mskEnd   = {PDW{1'b1}} << (PSHW'(PDW - 1) - me_q);      // ones in bits 0..me
        if (fz_q)
            mask_d = '0;
        else if (lkAhd_q[0])
            mask_d = '1;
        else if (lkAhd_q[1])
            mask_d = mskBegin | mskEnd;
        else
            mask_d = mskBegin & mskEnd;
        result_d = ins_q ? ((rot_q & mask_d) | (ra_q & ~mask_d)) : (rot_q & mask_d);
    end

    // CR0 from the merged result as a signed word
    always_comb begin
        cr0_d             = 4'b0000;
        cr0_d[3 - CR0_LT] = result_d[PDW-1];
        cr0_d[3 - CR0_GT] = ~result_d[PDW-1] & (result_d != '0);
        cr0_d[3 - CR0_EQ] = (result_d == '0);
        cr0_d[3 - CR0_SO] = so_q;
    end

    // Pipeline valid bits; reset and flush both discard everything in flight
    always_ff @(posedge CB) begin
        if (syncReset || flush) begin
            s1Vld_q  <= 1'b0;
            s2Vld_q  <= 1'b0;
            cr0Vld_q <= 1'b0;
        end else begin
            if (inRdy)
                s1Vld_q <= inVld;
            if (s2Load) begin
                s2Vld_q  <= s1Vld_q;
                cr0Vld_q <= s1Vld_q & rec_q;
            end
        end
    end

    // Output registers; only overwritten when a real op moves into stage 2
    always_ff @(posedge CB) begin
        if (syncReset) begin
            result_q <= '0;
            cr0_q    <= '0;
        end else if (s2Load && s1Vld_q) begin
            result_q <= result_d;
            cr0_q    <= cr0_d;
        end
    end

    assign outVld = s2Vld_q;
    assign cr0Vld = cr0Vld_q;
    assign result = result_q;
    assign cr0    = cr0_q;

endmodule

// File: tb/tb_p405s_srm_exec_pipe.sv
// Directed bench for the SRM execute pipe: single ops, stall sequence, flush and mid-stream reset.
// Latency: checks exact 2-cycle accept-to-outVld.
// Backpressure: exercises outRdy stalls and inRdy behaviour.
module tb_p405s_srm_exec_pipe;
    import p405s_srm_pkg::*;

    logic        CB = 1'b0;
    logic        syncReset;
    logic        flush;
    logic        inVld;
    logic        inRdy;
    logic [31:0] rsData;
    logic [31:0] raData;
    logic [4:0]  shAmt;
    logic [4:0]  mbField;
    logic [4:0]  meField;
    logic        forceZeroDcd;
    logic        insertOp;
    logic        recordOp;
    logic        soIn;
    logic        outVld;
    logic        outRdy;
    logic [31:0] result;
    logic [3:0]  cr0;
    logic        cr0Vld;

    int n_chk  = 0;
    int n_pass = 0;

    p405s_srm_exec_pipe dut (
        .CB           (CB),
        .syncReset    (syncReset),
        .flush        (flush),
        .inVld        (inVld),
        .inRdy        (inRdy),
        .rsData       (rsData),
        .raData       (raData),
        .shAmt        (shAmt),
        .mbField      (mbField),
        .meField      (meField),
        .forceZeroDcd (forceZeroDcd),
        .insertOp     (insertOp),
        .recordOp     (recordOp),
        .soIn         (soIn),
        .outVld       (outVld),
        .outRdy       (outRdy),
        .result       (result),
        .cr0          (cr0),
        .cr0Vld       (cr0Vld)
    );

    always #5 CB = ~CB;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] rs, input logic [31:0] ra, input logic [4:0] sh,
                         input logic [4:0] mb, input logic [4:0] me, input logic fz,
                         input logic ins, input logic rec, input logic so);
        inVld        = 1'b1;
        rsData       = rs;
        raData       = ra;
        shAmt        = sh;
        mbField      = mb;
        meField      = me;
        forceZeroDcd = fz;
        insertOp     = ins;
        recordOp     = rec;
        soIn         = so;
    endtask

    // One op through an idle pipe with outRdy high; checks exact latency and results
    task automatic run_op(input string tag, input logic [31:0] rs, input logic [31:0] ra,
                          input logic [4:0] sh, input logic [4:0] mb, input logic [4:0] me,
                          input logic fz, input logic ins, input logic rec, input logic so,
                          input logic [31:0] exp_res, input logic [3:0] exp_cr0, input logic exp_crv);
        @(negedge CB);
        outRdy = 1'b1;
        drive(rs, ra, sh, mb, me, fz, ins, rec, so);
        #1 chk({tag, ".inRdy"}, 32'(inRdy), 32'd1);
        @(negedge CB);
        inVld = 1'b0;
        #1 chk({tag, ".lat1"}, 32'(outVld), 32'd0);
        @(negedge CB);
        #1;
        chk({tag, ".outVld"}, 32'(outVld), 32'd1);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".cr0Vld"}, 32'(cr0Vld), 32'(exp_crv));
        if (exp_crv)
            chk({tag, ".cr0"}, 32'(cr0), 32'(exp_cr0));
    endtask

    // Load two ops with outRdy low so both stages are full
    task automatic fill_pipe(input string tag);
        @(negedge CB);
        outRdy = 1'b0;
        drive(32'h1111_1111, 32'h0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk({tag, ".rdy0"}, 32'(inRdy), 32'd1);
        @(negedge CB);
        drive(32'h2222_2222, 32'h0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk({tag, ".rdy1"}, 32'(inRdy), 32'd1);
        @(negedge CB);
        inVld = 1'b0;
        #1;
        chk({tag, ".fullRdy"}, 32'(inRdy), 32'd0);
        chk({tag, ".fullVld"}, 32'(outVld), 32'd1);
        chk({tag, ".fullRes"}, result, 32'h1111_1111);
    endtask

    logic [31:0] st_val [4];
    logic        exp_rdy [10];

    initial begin
        int acc;
        int pop;

        syncReset = 1'b1;
        flush     = 1'b0;
        outRdy    = 1'b1;
        inVld     = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        inVld     = 1'b0;

        // Reset state
        repeat (2) @(negedge CB);
        #1;
        chk("rst.outVld", 32'(outVld), 32'd0);
        chk("rst.cr0Vld", 32'(cr0Vld), 32'd0);
        chk("rst.result", result, 32'h0);
        chk("rst.cr0", 32'(cr0), 32'h0);
        syncReset = 1'b0;
        #1 chk("rst.inRdy", 32'(inRdy), 32'd1);

        // Basic rotate/mask
        run_op("rlwinm", 32'h1234_5678, 32'h0, 5'd4, 5'd0, 5'd27, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h2345_6780, 4'b0100, 1'b1);
        run_op("wrap", 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd28, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0,
               32'hF000_000F, 4'b1000, 1'b1);
        run_op("single", 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0400_0000, 4'b0000, 1'b0);
        run_op("wrapref", 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd30, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0,
               ref_mask(5'd30, 5'd1, 1'b0), 4'b0000, 1'b0);
        run_op("srw", 32'h1234_5678, 32'h0, 5'd28, 5'd4, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1,
               32'h0123_4567, 4'b0101, 1'b1);
        run_op("rlwimi", 32'h0000_00AB, 32'hFFFF_FFFF, 5'd8, 5'd16, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0,
               32'hFFFF_ABFF, 4'b0000, 1'b0);
        run_op("fz", 32'hDEAD_BEEF, 32'h0, 5'd3, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1,
               32'h0000_0000, 4'b0011, 1'b1);
        run_op("fzins", 32'hDEAD_BEEF, 32'h5A5A_5A5A, 5'd3, 5'd0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1,
               32'h5A5A_5A5A, 4'b0101, 1'b1);

        // Back-to-back 4 ops, outRdy low in cycles 3..5
        st_val  = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        acc = 0;
        pop = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CB);
            outRdy = !(c >= 3 && c <= 5);
            if (acc < 4)
                drive(st_val[acc], 32'h0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                inVld = 1'b0;
            #1;
            chk($sformatf("stall.rdy%0d", c), 32'(inRdy), 32'(exp_rdy[c]));
            if (outVld) begin
                if (pop < 4) begin
                    chk($sformatf("stall.res%0d", c), result, st_val[pop]);
                    if (outRdy)
                        pop++;
                end else begin
                    chk($sformatf("stall.dup%0d", c), 32'(outVld), 32'd0);
                end
            end
            if (inVld && inRdy)
                acc++;
        end
        inVld = 1'b0;
        chk("stall.accepted", 32'(acc), 32'd4);
        chk("stall.delivered", 32'(pop), 32'd4);

        // Flush with both stages full and outRdy low; offered op in flush cycle is dropped
        fill_pipe("fl");
        flush = 1'b1;
        drive(32'h3333_3333, 32'h0, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("fl.rdyDuring", 32'(inRdy), 32'd0);
        @(negedge CB);
        flush  = 1'b0;
        inVld  = 1'b0;
        outRdy = 1'b1;
        #1;
        chk("fl.outVld", 32'(outVld), 32'd0);
        chk("fl.cr0Vld", 32'(cr0Vld), 32'd0);
        chk("fl.inRdy", 32'(inRdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CB);
            #1 chk($sformatf("fl.ghost%0d", i), 32'(outVld), 32'd0);
        end
        run_op("postfl", 32'h8000_0001, 32'h0, 5'd1, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h0000_0003, 4'b0100, 1'b1);

        // syncReset mid-stream
        fill_pipe("sr");
        syncReset = 1'b1;
        @(negedge CB);
        syncReset = 1'b0;
        outRdy    = 1'b1;
        #1;
        chk("sr.outVld", 32'(outVld), 32'd0);
        chk("sr.cr0Vld", 32'(cr0Vld), 32'd0);
        chk("sr.result", result, 32'h0);
        chk("sr.cr0", 32'(cr0), 32'h0);
        chk("sr.inRdy", 32'(inRdy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CB);
            #1 chk($sformatf("sr.ghost%0d", i), 32'(outVld), 32'd0);
        end
        run_op("postsr", 32'h0F0F_0F0F, 32'h0, 5'd4, 5'd0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0,
               32'hF0F0_F0F0, 4'b1000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/p405s_srm_exec_pipe.md
Name: p405s_srm_exec_pipe

Overview:
- Two-stage pipelined shift/rotate/mask (SRM) execute stage for rlwinm, rlwnm, rlwimi, slw and srw.
- Consumes decoded mb/me/shift fields and operands. Rotates in stage 1. Builds the 32-bit mask and merges in stage 2.
- Sits between the execute-operand latch and the writeback mux.
- Mask wrap detection is delegated to the existing SRM mask look-ahead logic, instantiated in stage 1.

Parameters:
- DW, 32, datapath width (fixed by architecture; only 32 supported).
- SHW, 5, shift/mb/me field width.

Ports:
- CB  in  1  core clock; all state on rising edge.
- syncReset  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight operations (same cycle).
- inVld  in  1  operation offered.
- inRdy  out  1  stage 1 can accept this cycle.
- rsData  in  32  source operand to rotate.
- raData  in  32  insert target (rlwimi); ignored otherwise.
- shAmt  in  5  left-rotate amount (srw pre-converted by decode to 32-sh).
- mbField  in  5  mask begin.
- meField  in  5  mask end.
- forceZeroDcd  in  1  mask forced all-zero (slw/srw with shift ≥ 32).
- insertOp  in  1  1 = rlwimi merge with raData.
- recordOp  in  1  update CR0.
- soIn  in  1  XER[SO] copied into CR0.
- outVld  out  1  result valid.
- outRdy  in  1  writeback accepts.
- result  out  32  rotated/masked result.
- cr0  out  4  {LT,GT,EQ,SO}; valid only when cr0Vld=1.
- cr0Vld  out  1  outVld & recorded recordOp.

Behaviour:
- Bit numbering is big-endian: bit 0 = MSB.
- Reset: s1Vld, s2Vld, outVld, cr0Vld = 0. result and cr0 = 0. inRdy = 1 in the cycle after reset deasserts.
- Stage 1 (on accept, inVld & inRdy):
  - Register rot = rsData rotated left by shAmt.
  - Register raData, insertOp, recordOp, soIn, mbField, meField, forceZeroDcd.
  - Register the 2-bit propLookAhd from the look-ahead sub-block.
- Stage 2 mask definition:
  - forceZeroDcd=1 → mask = 0.
  - mb ≤ me → ones in bits mb..me.
  - me < mb (wrap) → ones in bits mb..31 and 0..me.
  - mb == me → single bit.
  - mb=0, me=31 → all ones.
  - Wrap selection must use the registered look-ahead bits, not a fresh comparator.
- Stage 2 merge:
  - result = insertOp ? (rot & mask) | (raData & ~mask) : (rot & mask).
  - Result is registered into the output flops.
- CR0, computed from result as signed 32-bit:
  - LT = result[0].
  - GT = ~result[0] & (result != 0).
  - EQ = (result == 0).
  - SO = soIn.
- Latency: 2 cycles accept-to-outVld with no stalls. Throughput 1 operation per cycle.
- Handshake:
  - Output holds result, cr0 and outVld stable while outVld & ~outRdy.
  - Stage advance: s2 loads when ~s2Vld | outRdy. s1 loads when ~s1Vld | s2 loads.
  - inRdy = ~s1Vld | s2Load. It is combinational from outRdy; no combinational path from inVld to inRdy.
  - A full pipeline with outRdy=0 holds all state, and inRdy = 0.
  - Simultaneous outRdy and a new accept: all stages shift in the same cycle, with no bubble.
- flush:
  - Clears s1Vld, s2Vld, outVld and cr0Vld next edge, regardless of outRdy.
  - An inVld presented in the flush cycle is not accepted (inRdy forced 0).
  - flush and syncReset together behave as reset.
- syncReset mid-operation: all in-flight operations are discarded. No partial output.
- Datapath flops need no reset; only valid bits and the output registers are reset.

Decomposition:
- Shared package p405s_srm_pkg:
  - SRM field widths (SHW=5, DW=32).
  - CR0 bit-index constants (LT=0, GT=1, EQ=2, SO=3).
  - A function computing the reference mask from mb/me/forceZero, for bench scoreboard use only.
- Sub-module: the existing SRM mask look-ahead block (p405s_srmMskLkAhd), instantiated once in stage 1.
- Rotator and mask decoder stay inline.

Test Plan:
- rsData=0x12345678, sh=4, mb=0, me=27, insert=0, record=1, soIn=0 → result 0x23456780 after 2 cycles; cr0=0b0100.
- rsData=0xFFFFFFFF, sh=0, mb=28, me=3 (wrap) → result 0xF000000F; mb=me=5 → result 0x04000000.
- rlwimi: rsData=0x000000AB, sh=8, mb=16, me=23, raData=0xFFFFFFFF → result 0xFFFFABFF.
- forceZeroDcd=1, insert=0, record=1, soIn=1 → result 0x00000000, cr0=0b0011. Same with insert=1, raData=0x5A5A5A5A → result 0x5A5A5A5A.
- Back-to-back 4 operations with outRdy low for cycles 3–5:
  - inRdy drops only when both stages are full.
  - Results emerge in order, each held stable while stalled, with no loss or duplication.
- flush asserted with both stages full and outRdy=0 → outVld=0 next cycle, inRdy=1 next cycle. A later operation completes normally. syncReset mid-stream behaves the same, and outputs read 0.
